// File: rtl/ternary_packer.sv
// Ternary packer: reduces uniform random bytes to coefficients in {0,1,2}
// (byte mod 3), packs eight 2-bit coefficients per 16-bit word and streams
// the words out with out_last marking the final word of each polynomial.
// The coefficient at index NS is always zero; it pads the last partial word.
//
// Handshakes: a transfer on either side happens only on a rising edge where
// valid and ready are both high. out_valid, once raised, holds with
// out_data/out_last stable until out_ready is sampled high. in_ready never
// depends on in_valid, and out_valid never depends on out_ready.
module ternary_packer #(
    parameter int N  = 701,
    parameter int NS = 700
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        PAD    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   pack_q, pack_d;
    logic [15:0]   odata_q, odata_d;
    logic          ovalid_q, ovalid_d;
    logic          olast_q, olast_d;
    logic          done_q, done_d;

    logic          out_free;
    logic          accept;
    logic [7:0]    residue;
    logic [1:0]    coef;
    logic [15:0]   pack_wr;

    // The output register can take a new word when empty or being emptied.
    assign out_free = !ovalid_q || out_ready;
    assign in_ready = (state_q == SAMPLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign residue  = in_data % 8'd3;
    assign coef     = residue[1:0];

    // Pack register with the incoming coefficient merged into its slot.
    // Slots above the write pointer are always zero, so OR-ing is exact.
    always_comb begin
        pack_wr = pack_q | ({14'd0, coef} << {cnt_q[2:0], 1'b0});
    end

    // Next-state, counter, pack and output-word logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        done_d   = 1'b0;

        // Current word leaves; a load below may replace it on the same edge.
        if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                    pack_d  = '0;
                end
            end
            SAMPLE: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q[2:0] == 3'd7) begin
                        odata_d  = pack_wr;
                        ovalid_d = 1'b1;
                        pack_d   = '0;
                    end else begin
                        pack_d = pack_wr;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                // Slot for index NS is already zero in pack_q; ship the partial word.
                if (out_free) begin
                    odata_d  = pack_q;
                    ovalid_d = 1'b1;
                    olast_d  = 1'b1;
                    pack_d   = '0;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (ovalid_q && out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pack_q   <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pack_q   <= pack_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            done_q   <= done_d;
        end
    end

    assign out_valid   = ovalid_q;
    assign out_data    = odata_q;
    assign out_last    = olast_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ternary_packer.sv
// Bench for ternary_packer: table-driven first-word mapping vectors plus
// directed multi-cycle sequences (full run, backpressure, mid-run reset,
// start while busy) checked by a word scoreboard.
module tb_ternary_packer;

    localparam int NS    = 700;
    localparam int WORDS = 88;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int words_seen = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;
    logic [16:0] exp_q[$];

    ternary_packer #(.N(701), .NS(NS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic release_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    endtask

    // Driver tasks
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int mode, input int i);
        case (mode)
            0:       return 8'h01;
            1:       return 8'h02;
            default: return 8'(i % 256);
        endcase
    endfunction

    // Reference model: expected word stream for a whole polynomial.
    task automatic build_exp(input int mode);
        logic [15:0] w;
        int idx;
        exp_q.delete();
        for (int wi = 0; wi < WORDS; wi++) begin
            w = 16'd0;
            for (int k = 0; k < 8; k++) begin
                idx = wi * 8 + k;
                if (idx < NS) w[2*k +: 2] = 2'(int'(byte_of(mode, idx)) % 3);
            end
            exp_q.push_back({(wi == WORDS - 1), w});
        end
    endtask

    task automatic wait_done(input int start_cnt);
        int t = 0;
        while (done_cnt == start_cnt && t < 3000) begin
            tick();
            t++;
        end
        check("done_seen", 32'(done_cnt - start_cnt), 32'd1);
    endtask

    // Scoreboard: every accepted word is compared against the expected queue.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got 0x%0h with no word expected at %0t", out_data, $time);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("word_data", 32'(out_data), 32'(e[15:0]));
                check("word_last", 32'(out_last), 32'(e[16]));
            end
            words_seen++;
        end
    end

    typedef struct {
        logic [63:0] bytes;   // byte 0 in bits [7:0]
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0;

        vecs[0] = '{bytes: 64'h80FF050403020100, exp: 16'h8924};
        vecs[1] = '{bytes: 64'h0101010101010101, exp: 16'h5555};
        vecs[2] = '{bytes: 64'h0202020202020202, exp: 16'hAAAA};
        vecs[3] = '{bytes: 64'h0303030303030303, exp: 16'h0000};
        vecs[4] = '{bytes: 64'h40302010817FFDFE, exp: 16'h4916};

        // Reset with random inputs: everything must read zero.
        do_reset(2);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        release_reset();

        // Table-driven first-word mapping.
        for (int v = 0; v < 5; v++) begin
            do_reset(1);
            release_reset();
            pulse_start();
            check("map_busy", 32'(busy), 1);
            for (int k = 0; k < 8; k++) begin
                logic [63:0] b;
                b = vecs[v].bytes;
                if (k == 7) check("map_not_early", 32'(out_valid), 0);
                send_byte(b[8*k +: 8]);
            end
            check("map_valid", 32'(out_valid), 1);
            check("map_data", 32'(out_data), 32'(vecs[v].exp));
            check("map_last", 32'(out_last), 0);
        end

        // Full run of 0x01 with start pulses in SAMPLE and DRAIN.
        do_reset(1);
        release_reset();
        build_exp(0);
        words_seen = 0;
        mon_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < NS; i++) begin
            if (i == 100) start = 1'b1;
            send_byte(byte_of(0, i));
            start = 1'b0;
        end
        out_ready = 1'b0;
        tick(); tick(); tick();
        check("drain_state", 32'(dbg_state), 32'd3);
        check("drain_valid", 32'(out_valid), 1);
        check("drain_last", 32'(out_last), 1);
        check("drain_data", 32'(out_data), 32'h0055);
        pulse_start();
        out_ready = 1'b1;
        wait_done(d0);
        check("full_words", 32'(words_seen), WORDS);
        check("full_queue_empty", 32'(exp_q.size()), 0);
        check("full_busy_after", 32'(busy), 0);
        tick(); tick(); tick();
        check("full_done_once", 32'(done_cnt - d0), 1);
        check("full_stay_idle", 32'(busy), 0);

        // Backpressure after word 0.
        mon_en = 1'b0;
        do_reset(1);
        release_reset();
        build_exp(2);
        words_seen = 0;
        mon_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(byte_of(2, i));
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = byte_of(2, 8);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 32'(exp_q[0][15:0]));
        end
        out_ready = 1'b1;
        for (int i = 8; i < NS; i++) send_byte(byte_of(2, i));
        wait_done(d0);
        check("bp_words", 32'(words_seen), WORDS);
        check("bp_queue_empty", 32'(exp_q.size()), 0);

        // Reset mid-run after 300 bytes, then a clean run of 0x02.
        mon_en = 1'b0;
        exp_q.delete();
        do_reset(1);
        release_reset();
        pulse_start();
        for (int i = 0; i < 300; i++) send_byte(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        build_exp(1);
        words_seen = 0;
        mon_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < NS; i++) send_byte(8'h02);
        wait_done(d0);
        check("mid_words", 32'(words_seen), WORDS);
        check("mid_queue_empty", 32'(exp_q.size()), 0);
        check("mid_busy_after", 32'(busy), 0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ternary_packer.md
TERNARY_PACKER -- requirements
Module: ternary_packer

Interface
REQ-001 SHALL have parameter N, default 701, number of ternary coefficients per polynomial.
REQ-002 SHALL have parameter NS, default 700, number of coefficients sampled from input bytes (N-1); the remaining coefficient is zero-padded.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a polynomial.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_data  input  8  uniform random byte from the hash stage.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a complete packed word.
REQ-010 SHALL have port out_data  output  16  8 coefficients, 2 bits each.
REQ-011 SHALL have port out_last  output  1  qualifies out_data as the final word of the polynomial.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-015 SHALL implement states IDLE, SAMPLE, PAD, DRAIN.
REQ-016 IDLE -> SAMPLE on start; start SHALL be ignored in all other states.
REQ-017 Each byte SHALL be accepted only on in_valid && in_ready, and reduced to the exact value in_data mod 3, encoded 2'b00/01/10; code 2'b11 SHALL never be produced.
REQ-018 Coefficient index i SHALL occupy pack bits [2*(i%8)+1 : 2*(i%8)]; unwritten slots of a word SHALL be zero.
REQ-019 in_ready SHALL equal (state==SAMPLE) && (!out_valid || out_ready).
REQ-020 The coefficient of an accepted byte SHALL appear in the pack register the next cycle; when slot 7 is written, that word SHALL be loaded into out_data, with out_valid high, on the same clock edge.
REQ-021 out_valid SHALL hold, and out_data/out_last SHALL stay stable, until out_ready is sampled high; a new word MAY load on the same edge the previous one is accepted.
REQ-022 After the NS-th accepted byte the state SHALL go SAMPLE -> PAD, with no further bytes accepted.
REQ-023 PAD SHALL write coefficient index NS as zero, then load the partial word with out_last=1; PAD SHALL hold while out_valid && !out_ready.
REQ-024 For N=701 the polynomial SHALL be exactly 88 words; only word 87 SHALL carry out_last.
REQ-025 PAD -> DRAIN on loading the final word; DRAIN -> IDLE when the final word is accepted; done SHALL pulse high for the single cycle after that acceptance.
REQ-026 in_valid while in_ready is low SHALL neither consume the byte nor change state.

Reset
REQ-027 When rst is high at a clock edge, state SHALL become IDLE, coefficient counter and pack register SHALL clear, and in_ready, out_valid, out_data, out_last, busy and done SHALL be 0 from the next cycle.
REQ-028 Reset mid-operation SHALL discard the partial polynomial; the next start SHALL begin again at coefficient index 0.
REQ-029 rst SHALL take priority over start and over every handshake in the same cycle.

Verification
REQ-030 Reset: assert rst for 2 cycles with random inputs -> all outputs 0, busy=0.
REQ-031 Mapping: start, feed bytes 00,01,02,03,04,05,FF,80 with out_ready=1 -> first word out_data=0x8924, out_last=0.
REQ-032 Full run: 700 bytes of 0x01, out_ready=1 -> words 0..86 = 0x5555, word 87 = 0x0055 with out_last=1, done pulses once, busy returns to 0.
REQ-033 Backpressure: hold out_ready=0 after word 0 is loaded -> in_ready=0, no bytes consumed, word 0 stable; release -> stream resumes with no lost or duplicated coefficient.
REQ-034 Reset mid-run: assert rst after 300 bytes, then start and 700 bytes of 0x02 -> 88 words, all coefficients 2 except the padded one.
REQ-035 Start while busy: pulse start in SAMPLE and in DRAIN -> no effect; word count and done timing unchanged.
